// File: rtl/trng_health_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : trng_health_ctrl_if
// Description : Bus bundle between the entropy front end / firmware and the
//               TRNG health sequencer (raw bit stream, health-test hooks,
//               status outputs).
// Revision    : 1.0 - initial release
// ============================================================================
interface trng_health_ctrl_if;
  logic       enable;
  logic       bit_valid;
  logic       bit_in;
  logic       ht_alarm;
  logic       fault_clear;
  logic       ht_restart;
  logic       bit_out;
  logic       bit_out_valid;
  logic [1:0] state;
  logic       ready;
  logic       fault;
  logic [7:0] alarm_count;

  // Driver side: source, health test and firmware controls
  modport master (
    output enable, bit_valid, bit_in, ht_alarm, fault_clear,
    input  ht_restart, bit_out, bit_out_valid, state, ready, fault, alarm_count
  );

  // Sequencer side
  modport slave (
    input  enable, bit_valid, bit_in, ht_alarm, fault_clear,
    output ht_restart, bit_out, bit_out_valid, state, ready, fault, alarm_count
  );
endinterface
`default_nettype wire

// File: rtl/trng_health_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trng_health_ctrl
// Description : Sequencer between the raw entropy stream, the repetition-count
//               health test and the TRNG output. Runs a startup test, forwards
//               bits only while healthy, counts alarm events in RUN and
//               latches a fault until firmware clears it.
// Revision    : 1.0 - initial release
// ============================================================================
module trng_health_ctrl #(
  parameter int STARTUP_SAMPLES = 1024,
  parameter int FAIL_LIMIT      = 2,
  parameter int CNT_W           = 11
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  trng_health_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STARTUP = 2'd1,
    ST_RUN     = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(STARTUP_SAMPLES - 1);
  localparam logic [7:0]       c_fail_limit = 8'(FAIL_LIMIT);
  localparam logic [7:0]       c_cnt_max    = 8'hFF;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_alarm_q;
  logic             r_ht_restart;
  logic             r_bit_out;
  logic             r_bit_out_valid;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [7:0]       r_alarm_count;

  logic             w_alarm_evt;
  logic [7:0]       w_alarm_inc;
  logic             w_enter_startup;
  logic             w_cnt_inc;
  logic             w_alarm_bump;
  logic             w_fwd;

  // Rising edge of the health-test alarm level
  assign w_alarm_evt = bus.ht_alarm & ~r_alarm_q;
  // Saturating next value of the RUN alarm counter
  assign w_alarm_inc = (r_alarm_count == c_cnt_max) ? c_cnt_max : r_alarm_count + 8'd1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    w_state_nxt     = r_state;
    w_enter_startup = 1'b0;
    w_cnt_inc       = 1'b0;
    w_alarm_bump    = 1'b0;
    w_fwd           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.enable) begin
          w_state_nxt     = ST_STARTUP;
          w_enter_startup = 1'b1;
        end
      end
      ST_STARTUP: begin
        if (!bus.enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_alarm_evt && !r_ht_restart) begin
          // An edge in the restart cycle is the stale level from before
          // the health test was reset, so it does not count.
          w_state_nxt = ST_FAULT;
        end else if (bus.bit_valid) begin
          if (r_sample_cnt == c_cnt_last) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!bus.enable) begin
          w_state_nxt = ST_IDLE;
        end else begin
          if (w_alarm_evt) begin
            w_alarm_bump = 1'b1;
            if (w_alarm_inc == c_fail_limit) begin
              w_state_nxt = ST_FAULT;
            end
          end
          // A bit sampled in the cycle that trips the fault is dropped
          w_fwd = bus.bit_valid && (w_state_nxt == ST_RUN);
        end
      end
      ST_FAULT: begin
        if (bus.fault_clear) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Edge detector, restart pulse, output bit register and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alarm_q       <= 1'b0;
      r_ht_restart    <= 1'b0;
      r_bit_out       <= 1'b0;
      r_bit_out_valid <= 1'b0;
      r_sample_cnt    <= '0;
      r_alarm_count   <= 8'd0;
    end else begin
      r_alarm_q       <= bus.ht_alarm;
      r_ht_restart    <= w_enter_startup;
      r_bit_out_valid <= w_fwd;
      if (w_fwd) begin
        r_bit_out <= bus.bit_in;
      end
      if (w_enter_startup) begin
        r_sample_cnt  <= '0;
        r_alarm_count <= 8'd0;
      end else begin
        if (w_cnt_inc) begin
          r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        end
        if (w_alarm_bump) begin
          r_alarm_count <= w_alarm_inc;
        end
      end
    end
  end

  assign bus.state         = r_state;
  assign bus.ready         = (r_state == ST_RUN);
  assign bus.fault         = (r_state == ST_FAULT);
  assign bus.ht_restart    = r_ht_restart;
  assign bus.bit_out       = r_bit_out;
  assign bus.bit_out_valid = r_bit_out_valid;
  assign bus.alarm_count   = r_alarm_count;

endmodule
`default_nettype wire

// File: tb/tb_trng_health_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trng_health_ctrl
// Description : Self-checking bench for trng_health_ctrl: reference model
//               compared every cycle plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trng_health_ctrl;

  localparam int SS = 8;
  localparam int FL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  trng_health_ctrl_if bus ();

  trng_health_ctrl #(
    .STARTUP_SAMPLES(SS),
    .FAIL_LIMIT     (FL),
    .CNT_W          (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.enable      = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.bit_in      = 1'b0;
    bus.ht_alarm    = 1'b0;
    bus.fault_clear = 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 startup, 2 run, 3 fault
  int m_state = 0, m_samples = 0, m_count = 0;
  bit m_out = 0, m_valid = 0, m_restart = 0, m_prev = 0;

  always @(posedge clk) begin
    bit ev, nvalid, nrestart;
    int nstate;
    if (!rst_n) begin
      m_state = 0; m_samples = 0; m_count = 0;
      m_out = 0; m_valid = 0; m_restart = 0; m_prev = 0;
    end else begin
      ev       = bus.ht_alarm && !m_prev;
      nstate   = m_state;
      nvalid   = 0;
      nrestart = 0;
      case (m_state)
        0: if (bus.enable) begin
             nstate = 1; nrestart = 1; m_samples = 0; m_count = 0;
           end
        1: if (!bus.enable) nstate = 0;
           else if (ev && !m_restart) nstate = 3;
           else if (bus.bit_valid) begin
             m_samples++;
             if (m_samples == SS) nstate = 2;
           end
        2: if (!bus.enable) nstate = 0;
           else begin
             if (ev) begin
               if (m_count < 255) m_count++;
               if (m_count == FL) nstate = 3;
             end
             if (nstate == 2 && bus.bit_valid) begin
               nvalid = 1; m_out = bus.bit_in;
             end
           end
        default: if (bus.fault_clear) nstate = 0;
      endcase
      m_state   = nstate;
      m_valid   = nvalid;
      m_restart = nrestart;
      m_prev    = bus.ht_alarm;
    end
    #1;
    chk("state",         int'(bus.state),         m_state);
    chk("ready",         int'(bus.ready),         int'(m_state == 2));
    chk("fault",         int'(bus.fault),         int'(m_state == 3));
    chk("ht_restart",    int'(bus.ht_restart),    int'(m_restart));
    chk("bit_out_valid", int'(bus.bit_out_valid), int'(m_valid));
    chk("bit_out",       int'(bus.bit_out),       int'(m_out));
    chk("alarm_count",   int'(bus.alarm_count),   m_count);
  end

  // One clock of stimulus; returns just after the edge that consumed it
  task automatic step(input logic rn, input logic en, input logic bv,
                      input logic bi, input logic al, input logic fc);
    @(negedge clk);
    rst_n           = rn;
    bus.enable      = en;
    bus.bit_valid   = bv;
    bus.bit_in      = bi;
    bus.ht_alarm    = al;
    bus.fault_clear = fc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1);
    chk("lit_rst_state", int'(bus.state), 0);
    chk("lit_rst_count", int'(bus.alarm_count), 0);
    chk("lit_rst_valid", int'(bus.bit_out_valid), 0);
    chk("lit_rst_restart", int'(bus.ht_restart), 0);

    // Startup with 8 clean samples
    step(1, 1, 0, 0, 0, 0);
    chk("lit_start_state", int'(bus.state), 1);
    chk("lit_start_restart", int'(bus.ht_restart), 1);
    for (int i = 0; i < SS; i++) begin
      step(1, 1, 1, 1'(i), 0, 0);
      if (i == 0) chk("lit_restart_one_pulse", int'(bus.ht_restart), 0);
      if (i == SS - 2) chk("lit_start_7th", int'(bus.state), 1);
    end
    chk("lit_run_state", int'(bus.state), 2);
    chk("lit_run_ready", int'(bus.ready), 1);
    chk("lit_run_valid0", int'(bus.bit_out_valid), 0);

    // Forward 1,0,1
    step(1, 1, 1, 1, 0, 0);
    chk("lit_fwd1", int'({bus.bit_out_valid, bus.bit_out}), 3);
    step(1, 1, 1, 0, 0, 0);
    chk("lit_fwd0", int'({bus.bit_out_valid, bus.bit_out}), 2);
    step(1, 1, 1, 1, 0, 0);
    chk("lit_fwd1b", int'({bus.bit_out_valid, bus.bit_out}), 3);
    step(1, 1, 0, 0, 0, 0);
    chk("lit_hold", int'({bus.bit_out_valid, bus.bit_out}), 1);

    // Alarm held high 10 cycles counts once, second pulse faults
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 1, 0);
    chk("lit_held_count", int'(bus.alarm_count), 1);
    chk("lit_held_state", int'(bus.state), 2);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0);
    chk("lit_second_count", int'(bus.alarm_count), 2);
    chk("lit_second_fault", int'(bus.fault), 1);
    chk("lit_dropped", int'(bus.bit_out_valid), 0);
    step(1, 1, 0, 0, 0, 0);
    chk("lit_fault_sticky", int'(bus.state), 3);

    // Clear with simultaneous alarm edge
    step(1, 1, 0, 0, 1, 1);
    chk("lit_clear_edge", int'(bus.state), 0);
    step(1, 1, 0, 0, 1, 0);
    chk("lit_restart2", int'(bus.ht_restart), 1);
    chk("lit_count_cleared", int'(bus.alarm_count), 0);

    // Alarm at startup sample 5
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0);
    chk("lit_su_fault", int'(bus.state), 3);
    step(1, 1, 0, 0, 0, 1);
    chk("lit_su_clear", int'(bus.state), 0);
    step(1, 1, 0, 0, 0, 0);
    chk("lit_restart3", int'(bus.ht_restart), 1);
    for (int i = 0; i < SS; i++) begin
      step(1, 1, 1, 0, 0, 0);
      if (i == SS - 2) chk("lit_recount_7th", int'(bus.state), 1);
    end
    chk("lit_run2", int'(bus.state), 2);

    // fault_clear in RUN ignored; one alarm then reset in RUN
    step(1, 1, 0, 0, 0, 1);
    chk("lit_clear_in_run", int'(bus.state), 2);
    step(1, 1, 0, 0, 1, 0);
    chk("lit_run_count1", int'(bus.alarm_count), 1);
    step(0, 1, 1, 1, 0, 0);
    chk("lit_rst_run_state", int'(bus.state), 0);
    chk("lit_rst_run_count", int'(bus.alarm_count), 0);

    // Reset mid-startup at sample 4
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    chk("lit_rst_su_state", int'(bus.state), 0);
    chk("lit_rst_su_restart", int'(bus.ht_restart), 0);

    // Full restart, then enable low in RUN with a valid bit
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < SS; i++) begin
      step(1, 1, 1, 0, 0, 0);
      if (i == SS - 2) chk("lit_after_rst_7th", int'(bus.state), 1);
    end
    chk("lit_run3", int'(bus.state), 2);
    step(1, 1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    chk("lit_dis_state", int'(bus.state), 0);
    chk("lit_dis_valid", int'(bus.bit_out_valid), 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
